// File: rtl/alu_load_sequencer_pkg.sv
// Shared definitions for the ALU loader: opcode encodings used by the alu
// and the 2-bit sequencer state encodings shown on the status LEDs.
package alu_load_sequencer_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOR = 4'h5;
  localparam logic [3:0] OP_SRA = 4'h6;
  localparam logic [3:0] OP_SRL = 4'h7;

  localparam logic [1:0] S_WAIT_A  = 2'd0;
  localparam logic [1:0] S_WAIT_B  = 2'd1;
  localparam logic [1:0] S_WAIT_OP = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

endpackage

// File: rtl/alu_load_sequencer_alu.sv
// Combinational alu: NB_DATA-wide result, wrapping arithmetic, no carry out.
// Shift opcodes use data_b as the shift amount.
module alu
  import alu_load_sequencer_pkg::*;
#(
  parameter int NB_DATA      = 4,
  parameter int NB_OPERATION = 4
) (
  input  logic [NB_DATA-1:0]      i_data_a,
  input  logic [NB_DATA-1:0]      i_data_b,
  input  logic [NB_OPERATION-1:0] i_op,
  output logic [NB_DATA-1:0]      o_result
);

  // opcode decode; unknown opcodes yield zero
  always_comb begin
    o_result = '0;
    case (i_op)
      NB_OPERATION'(OP_ADD): o_result = i_data_a + i_data_b;
      NB_OPERATION'(OP_SUB): o_result = i_data_a - i_data_b;
      NB_OPERATION'(OP_AND): o_result = i_data_a & i_data_b;
      NB_OPERATION'(OP_OR):  o_result = i_data_a | i_data_b;
      NB_OPERATION'(OP_XOR): o_result = i_data_a ^ i_data_b;
      NB_OPERATION'(OP_NOR): o_result = ~(i_data_a | i_data_b);
      NB_OPERATION'(OP_SRA): o_result = $signed(i_data_a) >>> i_data_b;
      NB_OPERATION'(OP_SRL): o_result = i_data_a >> i_data_b;
      default:               o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_load_sequencer_btn_debouncer.sv
// Button debouncer: the stable level follows the raw level only after it has
// differed for 2**NB_DEBOUNCE cycles; emits a one-cycle pulse on a stable press.
module btn_debouncer #(
  parameter int NB_DEBOUNCE = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic [NB_DEBOUNCE-1:0] count_r;
  logic                   stable_r;
  logic                   expired_s;

  assign expired_s = &count_r;

  // count while raw differs from stable; toggle stable when the count saturates
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_r  <= '0;
      stable_r <= 1'b0;
      o_pulse  <= 1'b0;
    end else begin
      o_pulse <= 1'b0;
      if (i_btn != stable_r) begin
        if (expired_s) begin
          count_r  <= '0;
          stable_r <= ~stable_r;
          o_pulse  <= ~stable_r;
        end else begin
          count_r <= count_r + NB_DEBOUNCE'(1);
        end
      end else begin
        count_r <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_load_sequencer.sv
// Operand/opcode loader in front of the alu: debounced buttons capture A, B and
// the opcode from the shared switch bus; the alu result is registered with valid/zero.
module alu_load_sequencer
  import alu_load_sequencer_pkg::*;
#(
  parameter int NB_DATA      = 4,
  parameter int NB_OPERATION = 4,
  parameter int NB_DEBOUNCE  = 20,
  parameter int SEQUENTIAL   = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [2:0]         i_load,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_valid,
  output logic               o_zero,
  output logic [1:0]         o_state
);

  logic [2:0]              pulse_s;
  logic                    load_a_s;
  logic                    load_b_s;
  logic                    load_op_s;
  logic                    wr_a_s;
  logic                    wr_b_s;
  logic                    wr_op_s;
  logic                    trigger_s;
  logic [1:0]              state_next_s;
  logic [1:0]              state_r;
  logic [NB_DATA-1:0]      data_a_r;
  logic [NB_DATA-1:0]      data_b_r;
  logic [NB_OPERATION-1:0] op_r;
  logic                    trigger_r;
  logic [NB_DATA-1:0]      alu_result_s;

  for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
    btn_debouncer #(.NB_DEBOUNCE(NB_DEBOUNCE)) u_debouncer (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_btn   (i_load[gi]),
      .o_pulse (pulse_s[gi])
    );
  end

  // A beats B beats OP when pulses coincide
  assign load_a_s  = pulse_s[0];
  assign load_b_s  = pulse_s[1] & ~pulse_s[0];
  assign load_op_s = pulse_s[2] & ~pulse_s[1] & ~pulse_s[0];

  // load enables and next state; out-of-order pulses are ignored in sequential mode
  always_comb begin
    wr_a_s       = 1'b0;
    wr_b_s       = 1'b0;
    wr_op_s      = 1'b0;
    trigger_s    = 1'b0;
    state_next_s = state_r;
    if (SEQUENTIAL != 0) begin
      case (state_r)
        S_WAIT_A, S_DONE: begin
          if (load_a_s) begin
            wr_a_s       = 1'b1;
            state_next_s = S_WAIT_B;
          end else begin
            state_next_s = state_r;
          end
        end
        S_WAIT_B: begin
          if (load_b_s) begin
            wr_b_s       = 1'b1;
            state_next_s = S_WAIT_OP;
          end else begin
            state_next_s = state_r;
          end
        end
        S_WAIT_OP: begin
          if (load_op_s) begin
            wr_op_s      = 1'b1;
            state_next_s = S_DONE;
          end else begin
            state_next_s = state_r;
          end
        end
        default: state_next_s = S_WAIT_A;
      endcase
      trigger_s = wr_op_s;
    end else begin
      wr_a_s       = load_a_s;
      wr_b_s       = load_b_s;
      wr_op_s      = load_op_s;
      state_next_s = load_op_s ? S_DONE : state_r;
      trigger_s    = load_a_s | load_b_s | load_op_s;
    end
  end

  // operand/opcode registers, state and the one-cycle result trigger
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_a_r  <= '0;
      data_b_r  <= '0;
      op_r      <= '0;
      state_r   <= S_WAIT_A;
      trigger_r <= 1'b0;
    end else begin
      if (wr_a_s) begin
        data_a_r <= i_data;
      end
      if (wr_b_s) begin
        data_b_r <= i_data;
      end
      if (wr_op_s) begin
        op_r <= i_data[NB_OPERATION-1:0];
      end
      state_r   <= state_next_s;
      trigger_r <= trigger_s;
    end
  end

  alu #(.NB_DATA(NB_DATA), .NB_OPERATION(NB_OPERATION)) u_alu (
    .i_data_a (data_a_r),
    .i_data_b (data_b_r),
    .i_op     (op_r),
    .o_result (alu_result_s)
  );

  // registered result; held between triggers, valid pulses once per trigger
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_result <= '0;
      o_valid  <= 1'b0;
      o_zero   <= 1'b1;
    end else begin
      o_valid <= trigger_r;
      if (trigger_r) begin
        o_result <= alu_result_s;
        o_zero   <= (alu_result_s == '0);
      end
    end
  end

  assign o_state = state_r;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Self-checking bench for alu_load_sequencer (SEQUENTIAL=1, NB_DEBOUNCE=3):
// table of A/B/OP vectors with a result scoreboard, plus hand-written corner cases.
module tb_alu_load_sequencer;
  import alu_load_sequencer_pkg::*;

  localparam int NB_DATA      = 4;
  localparam int NB_OPERATION = 4;
  localparam int NB_DEBOUNCE  = 3;

  logic               i_clock = 1'b0;
  logic               i_reset;
  logic [NB_DATA-1:0] i_data;
  logic [2:0]         i_load;
  logic [NB_DATA-1:0] o_result;
  logic               o_valid;
  logic               o_zero;
  logic [1:0]         o_state;

  alu_load_sequencer #(
    .NB_DATA(NB_DATA), .NB_OPERATION(NB_OPERATION),
    .NB_DEBOUNCE(NB_DEBOUNCE), .SEQUENTIAL(1)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_data  (i_data),
    .i_load  (i_load),
    .o_result(o_result),
    .o_valid (o_valid),
    .o_zero  (o_zero),
    .o_state (o_state)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [3:0] res;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] res;
    logic       zero;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;
  int   valid_cnt = 0;
  int   pulse_a_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // advance one cycle, sample on the falling edge and service the scoreboard
  task automatic tick();
    exp_t e;
    @(negedge i_clock);
    if (dut.pulse_s[0]) pulse_a_cnt++;
    if (o_valid) begin
      valid_cnt++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got o_valid=1 with result %0d, expected no pulse", o_result);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", o_result, e.res);
        check("sb_zero", o_zero, e.zero);
      end
    end
  endtask

  task automatic press(input logic [2:0] mask, input logic [3:0] data, input int hold);
    i_data = data;
    i_load = mask;
    repeat (hold) tick();
    i_load = 3'b000;
    repeat (14) tick();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) tick();
    i_reset = 1'b0;
    sb_q.delete();
    tick();
  endtask

  initial begin
    int p0;
    int v0;
    vecs[0] = '{4'd3,  4'd5,  OP_ADD, 4'd8,  1'b0};
    vecs[1] = '{4'd15, 4'd1,  OP_ADD, 4'd0,  1'b1};
    vecs[2] = '{4'd9,  4'd4,  OP_SUB, 4'd5,  1'b0};
    vecs[3] = '{4'd2,  4'd5,  OP_SUB, 4'd13, 1'b0};
    vecs[4] = '{4'd12, 4'd10, OP_AND, 4'd8,  1'b0};
    vecs[5] = '{4'd12, 4'd10, OP_OR,  4'd14, 1'b0};
    vecs[6] = '{4'd12, 4'd10, OP_XOR, 4'd6,  1'b0};
    vecs[7] = '{4'd12, 4'd10, OP_NOR, 4'd1,  1'b0};
    vecs[8] = '{4'd8,  4'd1,  OP_SRA, 4'd12, 1'b0};
    vecs[9] = '{4'd8,  4'd1,  OP_SRL, 4'd4,  1'b0};

    i_reset = 1'b1;
    i_data  = 4'd0;
    i_load  = 3'b000;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();

    // reset state and idle behaviour
    check("reset_result", o_result, 0);
    check("reset_zero", o_zero, 1);
    check("reset_valid", o_valid, 0);
    check("reset_state", o_state, S_WAIT_A);
    repeat (20) tick();
    check("idle_valid_count", valid_cnt, 0);
    check("idle_state", o_state, S_WAIT_A);

    // 2-cycle glitch on load A must not register
    p0 = pulse_a_cnt;
    press(3'b001, 4'd5, 2);
    check("glitch_pulses", pulse_a_cnt - p0, 0);
    check("glitch_state", o_state, S_WAIT_A);
    check("glitch_data_a", dut.data_a_r, 0);

    // B while waiting for A is ignored
    press(3'b010, 4'd7, 12);
    check("b_ignored_state", o_state, S_WAIT_A);
    check("b_ignored_data_b", dut.data_b_r, 0);

    // A and B together: A wins, one pulse from a held press
    p0 = pulse_a_cnt;
    press(3'b011, 4'd9, 12);
    check("held_press_pulses", pulse_a_cnt - p0, 1);
    check("ab_data_a", dut.data_a_r, 9);
    check("ab_data_b", dut.data_b_r, 0);
    check("ab_state", o_state, S_WAIT_B);

    do_reset();

    foreach (vecs[i]) begin
      v0 = valid_cnt;
      press(3'b001, vecs[i].a, 12);
      check($sformatf("vec%0d_state_a", i), o_state, S_WAIT_B);
      press(3'b010, vecs[i].b, 12);
      check($sformatf("vec%0d_state_b", i), o_state, S_WAIT_OP);
      sb_q.push_back('{vecs[i].res, vecs[i].zero});
      press(3'b100, vecs[i].op, 12);
      check($sformatf("vec%0d_state_op", i), o_state, S_DONE);
      check($sformatf("vec%0d_valid_pulses", i), valid_cnt - v0, 1);
      check($sformatf("vec%0d_pending", i), sb_q.size(), 0);
    end

    // reset while waiting for the opcode clears everything
    press(3'b001, 4'd6, 12);
    press(3'b010, 4'd6, 12);
    check("pre_reset_state", o_state, S_WAIT_OP);
    do_reset();
    check("midreset_state", o_state, S_WAIT_A);
    check("midreset_result", o_result, 0);
    check("midreset_zero", o_zero, 1);
    check("midreset_valid", o_valid, 0);
    check("midreset_data_a", dut.data_a_r, 0);
    check("midreset_data_b", dut.data_b_r, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
